// File: rtl/div3_serial_core.sv
// div3_serial_core: iterative exact divide-by-3.
//
// The dividend is consumed MSB-first, DIGIT bits per cycle. Each step folds the
// 2-bit running remainder and one digit into a (2+DIGIT)-bit value t, emits the
// quotient digit t/3 and keeps t mod 3 as the new remainder. With DIGIT=4 each
// step is a 6-input function.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   in_valid       dividend offered
//   in_ready       core idle, can accept a dividend
//   in_dividend    unsigned dividend, WIDTH bits
//   out_valid      result available (held until out_ready)
//   out_ready      consumer takes the result
//   out_quotient   floor(dividend / 3)
//   out_remainder  dividend mod 3, always 0..2
//
// Optional build macro DIV3_EARLY_SKIP_EN: leading all-zero digits of the
// dividend are skipped at acceptance, so RUN lasts max(1, significant digits)
// cycles. Results are identical either way.

module div3_serial_core #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [1:0]       out_remainder
);

   localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
   localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
   localparam int unsigned T_W        = DIGIT + 2;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [1:0]         rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_quot_q, out_quot_d;
   logic [1:0]         out_rem_q, out_rem_d;

   // One remainder-update step. rem_q <= 2 keeps t below 3*2^DIGIT, so the
   // quotient digit always fits in DIGIT bits.
   logic [DIGIT-1:0] digit;
   logic [T_W-1:0]   t;
   logic [DIGIT-1:0] qd;
   logic [1:0]       rem_nxt;

   assign digit   = shift_q[WIDTH-1 -: DIGIT];
   assign t       = {rem_q, digit};
   assign qd      = DIGIT'(t / T_W'(3));
   assign rem_nxt = 2'(t % T_W'(3));

   // Number of digit steps to skip at acceptance.
   logic [CNT_W-1:0] skip;

`ifdef DIV3_EARLY_SKIP_EN
   logic found;
   always_comb begin
      skip  = '0;
      found = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (!found && (in_dividend[i*DIGIT +: DIGIT] == '0)) begin
            skip = skip + CNT_W'(1);
         end else begin
            found = 1'b1;
         end
      end
      // A zero dividend still runs exactly one step.
      if (skip == CNT_W'(NUM_DIGITS)) begin
         skip = CNT_W'(NUM_DIGITS - 1);
      end
   end
`else
   always_comb begin
      skip = '0;
   end
`endif

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_quot_d  = out_quot_q;
      out_rem_d   = out_rem_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               // Skipped leading zero digits contribute zero quotient digits and
               // leave the remainder at 0, so only the dividend needs aligning.
               shift_d    = in_dividend << (skip * DIGIT);
               quot_d     = '0;
               rem_d      = '0;
               cnt_d      = skip;
               in_ready_d = 1'b0;
               state_d    = StRun;
            end
         end
         StRun: begin
            shift_d = shift_q << DIGIT;
            quot_d  = {quot_q[WIDTH-DIGIT-1:0], qd};
            rem_d   = rem_nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
               out_quot_d  = {quot_q[WIDTH-DIGIT-1:0], qd};
               out_rem_d   = rem_nxt;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_quot_q  <= '0;
         out_rem_q   <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_quot_q  <= out_quot_d;
         out_rem_q   <= out_rem_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_quotient  = out_quot_q;
   assign out_remainder = out_rem_q;

endmodule
